// File: rtl/cpu2fpga_pcie_pkg.sv
// cpu2fpga_pcie_pkg: shared types for the TX fetch engine.
// RDDM descriptor layout, completion ids, FSM states, flit constants.
package cpu2fpga_pcie_pkg;

    localparam logic [7:0] RDDM_DONE_ID = 8'h01;
    localparam logic [7:0] RDDM_LOW_ID  = 8'h02;
    localparam int         FLIT_BYTES   = 64;
    localparam int         FLIT_SHIFT   = 6;

    typedef struct packed {
        logic [18:0] rsvd;
        logic        immediate;
        logic [7:0]  desc_id;
        logic [63:0] dst_addr;
        logic [63:0] saddr_data;
        logic [17:0] nb_dwords;
    } pcie_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_DESC,
        ST_DESC_WRAP,
        ST_WAIT
    } state_t;

    function automatic logic [31:0] umin(input logic [31:0] a,
                                         input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cpu2fpga_buf_tracker.sv
// cpu2fpga_buf_tracker: BRAM ring occupancy and write pointer.
// Reports how many flits fit before the ring is full or wraps.
module cpu2fpga_buf_tracker #(
    parameter int BUF_AWIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_alloc,
    input  logic [BUF_AWIDTH:0]   i_alloc_size,
    input  logic                  i_free,
    input  logic [BUF_AWIDTH:0]   i_free_size,
    input  logic                  i_advance,
    input  logic [BUF_AWIDTH:0]   i_adv_size,
    output logic [BUF_AWIDTH-1:0] o_wr_ptr,
    output logic [BUF_AWIDTH:0]   o_bram_room
);

    localparam logic [BUF_AWIDTH:0] DEPTH = {1'b1, {BUF_AWIDTH{1'b0}}};

    logic [BUF_AWIDTH:0]   r_buf_used;
    logic [BUF_AWIDTH-1:0] r_wr_ptr;
    logic [BUF_AWIDTH:0]   w_used_add;
    logic [BUF_AWIDTH:0]   w_used_nxt;
    logic [BUF_AWIDTH:0]   w_room_used;
    logic [BUF_AWIDTH:0]   w_room_ptr;

    // Next occupancy: allocation first, then a saturating release
    always_comb begin
        w_used_add = r_buf_used + (i_alloc ? i_alloc_size : '0);
        w_used_nxt = w_used_add;
        if (i_free) begin
            w_used_nxt = (i_free_size > w_used_add) ? '0
                       : w_used_add - i_free_size;
        end
        w_room_used = DEPTH - r_buf_used;
        w_room_ptr  = DEPTH - {1'b0, r_wr_ptr};
        o_bram_room = (w_room_used < w_room_ptr) ? w_room_used : w_room_ptr;
    end

    // Occupancy and write pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_used <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_buf_used <= w_used_nxt;
            if (i_advance) begin
                r_wr_ptr <= r_wr_ptr + BUF_AWIDTH'(i_adv_size);
            end
        end
    end

    assign o_wr_ptr = r_wr_ptr;

endmodule

// File: rtl/cpu2fpga_pcie.sv
// cpu2fpga_pcie: host TX ring to FPGA BRAM fetch engine.
// Issues RDDM descriptors for pending flits, splitting at host wrap.
module cpu2fpga_pcie
    import cpu2fpga_pcie_pkg::*;
#(
    parameter int          RB_AWIDTH    = 10,
    parameter int          BUF_AWIDTH   = 9,
    parameter int          MAX_XFER     = 64,
    parameter logic [31:0] EP_BASE_ADDR = 32'h0008_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RB_AWIDTH-1:0]  tail,
    input  logic                  tail_valid,
    input  logic [63:0]           kmem_addr,
    input  logic [RB_AWIDTH:0]    rb_size,
    output logic [RB_AWIDTH-1:0]  out_head,
    input  logic                  rddm_desc_ready,
    output logic                  rddm_desc_valid,
    output logic [173:0]          rddm_desc_data,
    input  logic                  rddm_status_valid,
    input  logic [7:0]            rddm_status_id,
    input  logic                  buf_free_valid,
    input  logic [BUF_AWIDTH:0]   buf_free_size,
    output logic                  fetch_done,
    output logic [BUF_AWIDTH-1:0] fetch_base_addr,
    output logic [BUF_AWIDTH:0]   fetch_size,
    output logic [31:0]           dma_queue_full_cnt,
    output logic [31:0]           fpga_buf_full_cnt
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [RB_AWIDTH-1:0]  r_tail;
    logic [RB_AWIDTH-1:0]  r_head;
    logic [BUF_AWIDTH:0]   r_xfer;
    logic                  r_wrap;
    logic                  r_rdy_d1;
    logic                  r_rdy_d2;
    logic                  r_desc_valid;
    pcie_desc_t            r_desc;
    logic                  r_fetch_done;
    logic [BUF_AWIDTH-1:0] r_fetch_base;
    logic [BUF_AWIDTH:0]   r_fetch_size;
    logic [31:0]           r_dq_cnt;
    logic [31:0]           r_bf_cnt;

    logic [RB_AWIDTH:0]    w_pending;
    logic [BUF_AWIDTH-1:0] w_wr_ptr;
    logic [BUF_AWIDTH:0]   w_room;
    logic [31:0]           w_xfer_c;
    logic [31:0]           w_calc_end;
    logic [31:0]           w_end;
    logic [31:0]           w_low;
    logic [31:0]           w_high;
    logic [31:0]           w_head_nxt;
    logic [63:0]           w_src_lo;
    logic [63:0]           w_src_hi;
    logic [63:0]           w_dst;
    logic                  w_dma_ctrl_ready;
    logic                  w_issue;
    logic                  w_issue_hi;
    logic                  w_done;
    logic                  w_calc_ok;
    logic                  w_dq_stall;
    logic                  w_bf_stall;
    pcie_desc_t            w_desc;

    cpu2fpga_buf_tracker #(
        .BUF_AWIDTH (BUF_AWIDTH)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alloc      (w_issue),
        .i_alloc_size (r_xfer),
        .i_free       (buf_free_valid),
        .i_free_size  (buf_free_size),
        .i_advance    (w_done),
        .i_adv_size   (r_xfer),
        .o_wr_ptr     (w_wr_ptr),
        .o_bram_room  (w_room)
    );

    assign w_dma_ctrl_ready = rddm_desc_ready & r_rdy_d2;

    // Fetch sizing, host/BRAM addresses and head advance
    always_comb begin
        w_pending = (r_tail >= r_head)
                  ? ({1'b0, r_tail} - {1'b0, r_head})
                  : (rb_size - {1'b0, r_head} + {1'b0, r_tail});
        w_xfer_c   = umin(umin(32'(w_pending), 32'(MAX_XFER)), 32'(w_room));
        w_calc_end = 32'(r_head) + w_xfer_c;
        w_end      = 32'(r_head) + 32'(r_xfer);
        w_low      = 32'(rb_size) - 32'(r_head);
        w_high     = 32'(r_xfer) - w_low;
        w_head_nxt = (w_end >= 32'(rb_size)) ? w_end - 32'(rb_size) : w_end;
        w_src_hi   = kmem_addr + 64'(FLIT_BYTES);
        w_src_lo   = w_src_hi + (64'(r_head) << FLIT_SHIFT);
        w_dst      = 64'(EP_BASE_ADDR) + (64'(w_wr_ptr) << FLIT_SHIFT);
    end

    // Descriptor contents for the current issue slot
    always_comb begin
        w_desc = '0;
        w_desc.immediate = 1'b0;
        if (r_state == ST_DESC_WRAP) begin
            w_desc.desc_id    = RDDM_DONE_ID;
            w_desc.saddr_data = w_src_hi;
            w_desc.dst_addr   = w_dst + (64'(w_low) << FLIT_SHIFT);
            w_desc.nb_dwords  = 18'(w_high << 4);
        end else if (r_wrap) begin
            w_desc.desc_id    = RDDM_LOW_ID;
            w_desc.saddr_data = w_src_lo;
            w_desc.dst_addr   = w_dst;
            w_desc.nb_dwords  = 18'(w_low << 4);
        end else begin
            w_desc.desc_id    = RDDM_DONE_ID;
            w_desc.saddr_data = w_src_lo;
            w_desc.dst_addr   = w_dst;
            w_desc.nb_dwords  = 18'(32'(r_xfer) << 4);
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_hi  = 1'b0;
        w_done      = 1'b0;
        w_calc_ok   = 1'b0;
        w_dq_stall  = 1'b0;
        w_bf_stall  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pending != '0) w_state_nxt = ST_CALC;
            end
            ST_CALC: begin
                if (w_xfer_c == '0) begin
                    w_bf_stall = 1'b1;
                end else begin
                    w_calc_ok   = 1'b1;
                    w_state_nxt = ST_DESC;
                end
            end
            ST_DESC: begin
                if (w_dma_ctrl_ready) begin
                    w_issue     = 1'b1;
                    w_state_nxt = r_wrap ? ST_DESC_WRAP : ST_WAIT;
                end else begin
                    w_dq_stall = 1'b1;
                end
            end
            ST_DESC_WRAP: begin
                if (w_dma_ctrl_ready) begin
                    w_issue_hi  = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_dq_stall = 1'b1;
                end
            end
            ST_WAIT: begin
                if (rddm_status_valid && rddm_status_id == RDDM_DONE_ID) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, fetch bookkeeping, descriptor and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tail       <= '0;
            r_head       <= '0;
            r_xfer       <= '0;
            r_wrap       <= 1'b0;
            r_rdy_d1     <= 1'b0;
            r_rdy_d2     <= 1'b0;
            r_desc_valid <= 1'b0;
            r_desc       <= '0;
            r_fetch_done <= 1'b0;
            r_fetch_base <= '0;
            r_fetch_size <= '0;
            r_dq_cnt     <= '0;
            r_bf_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rdy_d1     <= rddm_desc_ready;
            r_rdy_d2     <= r_rdy_d1;
            r_desc_valid <= w_issue | w_issue_hi;
            r_fetch_done <= w_done;
            if (tail_valid) r_tail <= tail;
            if (w_calc_ok) begin
                r_xfer <= (BUF_AWIDTH + 1)'(w_xfer_c);
                r_wrap <= (w_calc_end > 32'(rb_size));
            end
            if (w_issue | w_issue_hi) r_desc <= w_desc;
            if (w_done) begin
                r_head       <= RB_AWIDTH'(w_head_nxt);
                r_fetch_base <= w_wr_ptr;
                r_fetch_size <= r_xfer;
            end
            if (w_dq_stall) r_dq_cnt <= r_dq_cnt + 32'd1;
            if (w_bf_stall) r_bf_cnt <= r_bf_cnt + 32'd1;
        end
    end

    assign out_head           = r_head;
    assign rddm_desc_valid    = r_desc_valid;
    assign rddm_desc_data     = r_desc;
    assign fetch_done         = r_fetch_done;
    assign fetch_base_addr    = r_fetch_base;
    assign fetch_size         = r_fetch_size;
    assign dma_queue_full_cnt = r_dq_cnt;
    assign fpga_buf_full_cnt  = r_bf_cnt;

endmodule

// File: tb/tb_cpu2fpga_pcie.sv
// tb_cpu2fpga_pcie: directed table-driven bench for cpu2fpga_pcie.
// Fetch vectors in a table plus hand sequences for stalls and reset.
module tb_cpu2fpga_pcie;
    import cpu2fpga_pcie_pkg::*;

    localparam logic [63:0] KMEM = 64'h0000_0001_2340_0000;
    localparam logic [63:0] EP   = 64'h0000_0000_0008_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [9:0]   tail;
    logic         tail_valid;
    logic [63:0]  kmem_addr;
    logic [10:0]  rb_size;
    logic [9:0]   out_head;
    logic         rddm_desc_ready;
    logic         rddm_desc_valid;
    logic [173:0] rddm_desc_data;
    logic         rddm_status_valid;
    logic [7:0]   rddm_status_id;
    logic         buf_free_valid;
    logic [9:0]   buf_free_size;
    logic         fetch_done;
    logic [8:0]   fetch_base_addr;
    logic [9:0]   fetch_size;
    logic [31:0]  dma_queue_full_cnt;
    logic [31:0]  fpga_buf_full_cnt;

    cpu2fpga_pcie dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tail               (tail),
        .tail_valid         (tail_valid),
        .kmem_addr          (kmem_addr),
        .rb_size            (rb_size),
        .out_head           (out_head),
        .rddm_desc_ready    (rddm_desc_ready),
        .rddm_desc_valid    (rddm_desc_valid),
        .rddm_desc_data     (rddm_desc_data),
        .rddm_status_valid  (rddm_status_valid),
        .rddm_status_id     (rddm_status_id),
        .buf_free_valid     (buf_free_valid),
        .buf_free_size      (buf_free_size),
        .fetch_done         (fetch_done),
        .fetch_base_addr    (fetch_base_addr),
        .fetch_size         (fetch_size),
        .dma_queue_full_cnt (dma_queue_full_cnt),
        .fpga_buf_full_cnt  (fpga_buf_full_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] rb;
        bit          st;
        logic [9:0]  tl;
        int          nd;
        longint      s0, d0;
        int          f0;
        longint      s1, d1;
        int          f1;
        int          hd, sz, bs;
    } vec_t;

    vec_t       vt[15];
    pcie_desc_t dq[$];
    int         done_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(negedge clk) begin
        if (rddm_desc_valid) dq.push_back(rddm_desc_data);
        if (fetch_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(int rb, bit st, int tl, int nd,
                                longint s0, longint d0, int f0,
                                longint s1, longint d1, int f1,
                                int hd, int sz, int bs);
        vec_t v;
        v.rb = 11'(rb); v.st = st; v.tl = 10'(tl); v.nd = nd;
        v.s0 = s0; v.d0 = d0; v.f0 = f0;
        v.s1 = s1; v.d1 = d1; v.f1 = f1;
        v.hd = hd; v.sz = sz; v.bs = bs;
        return v;
    endfunction

    task automatic chk_desc(input string nm, input pcie_desc_t d,
                            input logic [7:0] id, input longint s,
                            input longint ds, input int f);
        chk({nm, ".id"},  64'(d.desc_id), 64'(id));
        chk({nm, ".src"}, d.saddr_data, KMEM + 64'(s));
        chk({nm, ".dst"}, d.dst_addr, EP + 64'(ds));
        chk({nm, ".nb"},  64'(d.nb_dwords), 64'(f * 16));
        chk({nm, ".imm"}, 64'(d.immediate), 64'd0);
    endtask

    task automatic run_fetch(input int k, input vec_t v);
        int n;
        int dc;
        string tag;
        pcie_desc_t d;
        tag = $sformatf("v%0d", k);
        rb_size = v.rb;
        if (v.st) begin
            tail = v.tl;
            tail_valid = 1'b1;
            tick();
            tail_valid = 1'b0;
        end
        n = 0;
        while (dq.size() < v.nd && n < 300) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({tag, ".ndesc"}, 64'(dq.size()), 64'(v.nd));
        if (dq.size() >= 1) begin
            d = dq.pop_front();
            chk_desc({tag, ".d0"}, d,
                     (v.nd == 2) ? RDDM_LOW_ID : RDDM_DONE_ID,
                     v.s0, v.d0, v.f0);
        end
        if (v.nd == 2 && dq.size() >= 1) begin
            d = dq.pop_front();
            chk_desc({tag, ".d1"}, d, RDDM_DONE_ID, v.s1, v.d1, v.f1);
        end
        dq.delete();
        dc = done_cnt;
        if (v.nd == 2) begin
            rddm_status_valid = 1'b1;
            rddm_status_id = RDDM_LOW_ID;
            tick();
            rddm_status_valid = 1'b0;
            repeat (3) tick();
            chk({tag, ".low_id_ignored"}, 64'(done_cnt), 64'(dc));
        end
        rddm_status_valid = 1'b1;
        rddm_status_id = RDDM_DONE_ID;
        tick();
        rddm_status_valid = 1'b0;
        n = 0;
        while (done_cnt == dc && n < 50) begin
            tick();
            n++;
        end
        chk({tag, ".done"}, 64'(done_cnt), 64'(dc + 1));
        chk({tag, ".size"}, 64'(fetch_size), 64'(v.sz));
        chk({tag, ".base"}, 64'(fetch_base_addr), 64'(v.bs));
        chk({tag, ".head"}, 64'(out_head), 64'(v.hd));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".head"},  64'(out_head), 64'd0);
        chk({tag, ".valid"}, 64'(rddm_desc_valid), 64'd0);
        chk({tag, ".data"},  64'(rddm_desc_data == '0), 64'd1);
        chk({tag, ".done"},  64'(fetch_done), 64'd0);
        chk({tag, ".size"},  64'(fetch_size), 64'd0);
        chk({tag, ".base"},  64'(fetch_base_addr), 64'd0);
        chk({tag, ".dqcnt"}, 64'(dma_queue_full_cnt), 64'd0);
        chk({tag, ".bfcnt"}, 64'(fpga_buf_full_cnt), 64'd0);
    endtask

    initial begin
        int n;
        int dc;
        logic [31:0] c0;

        vt[0]  = mk(16,   1, 5,   1, 64,    0,     5,  0,  0,    0, 5,   5,  0);
        vt[1]  = mk(16,   1, 14,  1, 384,   320,   9,  0,  0,    0, 14,  9,  5);
        vt[2]  = mk(16,   1, 3,   2, 960,   896,   2,  64, 1024, 3, 3,   5,  14);
        vt[3]  = mk(16,   1, 12,  1, 256,   1216,  9,  0,  0,    0, 12,  9,  19);
        vt[4]  = mk(16,   1, 0,   1, 832,   1792,  4,  0,  0,    0, 0,   4,  28);
        vt[5]  = mk(200,  1, 100, 1, 64,    2048,  64, 0,  0,    0, 64,  64, 32);
        vt[6]  = mk(200,  0, 0,   1, 4160,  6144,  36, 0,  0,    0, 100, 36, 96);
        vt[7]  = mk(1000, 1, 490, 1, 6464,  8448,  64, 0,  0,    0, 164, 64, 132);
        vt[8]  = mk(1000, 0, 0,   1, 10560, 12544, 64, 0,  0,    0, 228, 64, 196);
        vt[9]  = mk(1000, 0, 0,   1, 14656, 16640, 64, 0,  0,    0, 292, 64, 260);
        vt[10] = mk(1000, 0, 0,   1, 18752, 20736, 64, 0,  0,    0, 356, 64, 324);
        vt[11] = mk(1000, 0, 0,   1, 22848, 24832, 64, 0,  0,    0, 420, 64, 388);
        vt[12] = mk(1000, 0, 0,   1, 26944, 28928, 60, 0,  0,    0, 480, 60, 452);
        vt[13] = mk(1000, 0, 0,   1, 30784, 0,     8,  0,  0,    0, 488, 8,  0);
        vt[14] = mk(1000, 0, 0,   1, 31296, 512,   2,  0,  0,    0, 490, 2,  8);

        rst_n = 1'b0;
        tail = '0;
        tail_valid = 1'b0;
        kmem_addr = KMEM;
        rb_size = 11'd16;
        rddm_desc_ready = 1'b1;
        rddm_status_valid = 1'b0;
        rddm_status_id = '0;
        buf_free_valid = 1'b0;
        buf_free_size = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 13; i++) run_fetch(i, vt[i]);

        repeat (10) tick();
        chk("bfull.no_desc", 64'(dq.size()), 64'd0);
        chk("bfull.cnt_ge8", 64'(fpga_buf_full_cnt >= 32'd8), 64'd1);
        c0 = fpga_buf_full_cnt;
        tick();
        chk("bfull.cnt_inc", 64'(fpga_buf_full_cnt), 64'(c0 + 32'd1));
        buf_free_valid = 1'b1;
        buf_free_size = 10'd8;
        tick();
        buf_free_valid = 1'b0;
        run_fetch(13, vt[13]);

        rddm_desc_ready = 1'b0;
        tick();
        buf_free_valid = 1'b1;
        buf_free_size = 10'd64;
        tick();
        buf_free_valid = 1'b0;
        repeat (14) tick();
        chk("dq.no_desc", 64'(dq.size()), 64'd0);
        chk("dq.cnt_ge10", 64'(dma_queue_full_cnt >= 32'd10), 64'd1);
        rddm_desc_ready = 1'b1;
        run_fetch(14, vt[14]);

        tail = 10'd495;
        tail_valid = 1'b1;
        tick();
        tail_valid = 1'b0;
        n = 0;
        while (dq.size() < 1 && n < 100) begin
            tick();
            n++;
        end
        chk("rst.desc_seen", 64'(dq.size()), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        repeat (2) tick();
        rst_n = 1'b1;
        dq.delete();
        dc = done_cnt;
        tick();
        rddm_status_valid = 1'b1;
        rddm_status_id = RDDM_DONE_ID;
        tick();
        rddm_status_valid = 1'b0;
        repeat (10) tick();
        chk("late.no_done", 64'(done_cnt), 64'(dc));
        chk("late.head", 64'(out_head), 64'd0);
        chk("late.no_desc", 64'(dq.size()), 64'd0);
        chk("late.size", 64'(fetch_size), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
